// File: rtl/stage_mm.sv
// Memory stage: issues one data-bus transaction per load/store, formats load
// data, and registers the result into the write-back pipeline registers.
module stage_mm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall,
  input  logic        flush,
  input  logic        reg_wr,
  input  logic [4:0]  reg_addr_rd,
  input  logic [31:0] reg_data_rd,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  mem_size,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_req,
  output logic        misalign,
  output logic        out_reg_wr,
  output logic [4:0]  out_reg_addr_rd,
  output logic [31:0] out_reg_data_rd,
  output logic        out_flush
);

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [DATA_W-1:0]       addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              off_q, off_d;
  logic [DATA_W-1:0]       ld_data_q, ld_data_d;
  logic                    misalign_q, misalign_d;
  logic                    out_wr_q, out_wr_d;
  logic [REG_ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_flush_q, out_flush_d;

  logic mem_op, bad, issue;

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] size,
                                                     input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (size)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] load_format(input logic [2:0] size,
                                                     input logic [1:0] off,
                                                     input logic [DATA_W-1:0] w);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_BU:   r = {24'd0, b};
      SZ_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign mem_op = en && !flush && (mem_rd || mem_wr);
  assign bad    = mem_op && ((((mem_size == SZ_H) || (mem_size == SZ_HU)) && reg_data_rd[0]) ||
                             ((mem_size == SZ_W) && (reg_data_rd[1:0] != 2'b00)));
  assign issue  = (state_q == S_IDLE) && mem_op && !bad;

  assign stall_req = issue || (state_q == S_BUSY);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    ld_data_d   = ld_data_q;
    misalign_d  = 1'b0;
    out_wr_d    = out_wr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_flush_d = out_flush_q;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_BUSY;
          req_d   = 1'b1;
          we_d    = mem_wr;
          addr_d  = {reg_data_rd[31:2], 2'b00};
          be_d    = mem_wr ? store_be(mem_size, reg_data_rd[1:0]) : 4'b1111;
          wdata_d = store_lanes(mem_size, store_data);
          size_d  = mem_size;
          off_d   = reg_data_rd[1:0];
        end else if (bad) begin
          misalign_d = 1'b1;
        end
      end
      // The bus completes regardless of global stall or flush once issued.
      S_BUSY: begin
        if (dmem_ack) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          ld_data_d = load_format(size_q, off_q, dmem_rdata);
        end
      end
      S_DONE: begin
        if (en && !stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (en && !stall) begin
      if (stall_req) begin
        out_wr_d    = 1'b0;
        out_flush_d = 1'b1;
      end else begin
        out_wr_d    = reg_wr && !flush && !mem_wr && !bad;
        out_addr_d  = reg_addr_rd;
        out_data_d  = mem_rd ? ld_data_q : reg_data_rd;
        out_flush_d = flush;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      ld_data_q   <= '0;
      misalign_q  <= 1'b0;
      out_wr_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_flush_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      ld_data_q   <= ld_data_d;
      misalign_q  <= misalign_d;
      out_wr_q    <= out_wr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_flush_q <= out_flush_d;
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_be         = be_q;
  assign dmem_wdata      = wdata_q;
  assign misalign        = misalign_q;
  assign out_reg_wr      = out_wr_q;
  assign out_reg_addr_rd = out_addr_q;
  assign out_reg_data_rd = out_data_q;
  assign out_flush       = out_flush_q;

endmodule

// File: tb/tb_stage_mm.sv
// Directed bench for stage_mm: ALU pass-through, loads/stores, misalign,
// global stall hold in DONE, flush bubble and reset during a transaction.
module tb_stage_mm;

  logic        clk = 1'b0;
  logic        rst_n, en, stall, flush, reg_wr, mem_rd, mem_wr, dmem_ack;
  logic [4:0]  reg_addr_rd;
  logic [31:0] reg_data_rd, store_data, dmem_rdata;
  logic [2:0]  mem_size;
  logic        dmem_req, dmem_we, stall_req, misalign, out_reg_wr, out_flush;
  logic [31:0] dmem_addr, dmem_wdata, out_reg_data_rd;
  logic [3:0]  dmem_be;
  logic [4:0]  out_reg_addr_rd;

  int checks = 0;
  int errors = 0;
  int nstall;

  stage_mm dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
    .reg_wr(reg_wr), .reg_addr_rd(reg_addr_rd), .reg_data_rd(reg_data_rd),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_req(stall_req), .misalign(misalign), .out_reg_wr(out_reg_wr),
    .out_reg_addr_rd(out_reg_addr_rd), .out_reg_data_rd(out_reg_data_rd),
    .out_flush(out_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reg_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; flush = 1'b0;
    dmem_ack = 1'b0; mem_size = 3'b000; reg_addr_rd = 5'd0;
    reg_data_rd = 32'd0; store_data = 32'd0;
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] word, input logic [31:0] exp);
    set_idle();
    mem_rd = 1'b1; reg_wr = 1'b1; reg_addr_rd = 5'd4; reg_data_rd = addr; mem_size = size;
    tick();
    chk({tag, "_req"}, dmem_req, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = word;
    tick();
    dmem_ack = 1'b0;
    tick();
    chk({tag, "_wr"}, out_reg_wr, 1'b1);
    chk({tag, "_data"}, out_reg_data_rd, exp);
    set_idle();
  endtask

  task automatic run_store(input string tag, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
    set_idle();
    mem_wr = 1'b1; reg_wr = 1'b1; reg_addr_rd = 5'd6; reg_data_rd = addr;
    mem_size = size; store_data = data;
    tick();
    chk({tag, "_req"}, dmem_req, 1'b1);
    chk({tag, "_we"}, dmem_we, 1'b1);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, dmem_be, exp_be);
    chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    chk({tag, "_regwr"}, out_reg_wr, 1'b0);
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; dmem_rdata = 32'd0;
    set_idle();
    #12;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_be", dmem_be, 4'b0000);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_outwr", out_reg_wr, 1'b0);
    chk("rst_outaddr", out_reg_addr_rd, 5'd0);
    chk("rst_outdata", out_reg_data_rd, 32'd0);
    chk("rst_outflush", out_flush, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // ALU pass-through
    reg_wr = 1'b1; reg_addr_rd = 5'd5; reg_data_rd = 32'h0000_1234;
    #1;
    chk("alu_stallreq", stall_req, 1'b0);
    tick();
    chk("alu_wr", out_reg_wr, 1'b1);
    chk("alu_addr", out_reg_addr_rd, 5'd5);
    chk("alu_data", out_reg_data_rd, 32'h0000_1234);
    chk("alu_flush", out_flush, 1'b0);

    // LW misaligned
    set_idle();
    mem_rd = 1'b1; reg_wr = 1'b1; reg_addr_rd = 5'd9; reg_data_rd = 32'h101; mem_size = 3'b010;
    #1;
    chk("mis_stallreq", stall_req, 1'b0);
    tick();
    chk("mis_req", dmem_req, 1'b0);
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_wr", out_reg_wr, 1'b0);
    set_idle();
    tick();
    chk("mis_pulse_end", misalign, 1'b0);

    // LB at 0x103, two cycles in BUSY
    set_idle();
    mem_rd = 1'b1; reg_wr = 1'b1; reg_addr_rd = 5'd7; reg_data_rd = 32'h103;
    mem_size = 3'b000; dmem_rdata = 32'h80FF_0000;
    nstall = 0;
    #1; if (stall_req) nstall++;
    tick();
    chk("lb_req", dmem_req, 1'b1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", dmem_we, 1'b0);
    chk("lb_be", dmem_be, 4'b1111);
    chk("lb_bubble", out_flush, 1'b1);
    #1; if (stall_req) nstall++;
    tick();
    chk("lb_req_hold", dmem_req, 1'b1);
    dmem_ack = 1'b1;
    #1; if (stall_req) nstall++;
    tick();
    dmem_ack = 1'b0;
    chk("lb_req_drop", dmem_req, 1'b0);
    #1; if (stall_req) nstall++;
    chk("lb_done_stallreq", stall_req, 1'b0);
    tick();
    chk("lb_stall_cycles", nstall, 3);
    chk("lb_wr", out_reg_wr, 1'b1);
    chk("lb_rd", out_reg_addr_rd, 5'd7);
    chk("lb_data", out_reg_data_rd, 32'hFFFF_FF80);

    run_store("sh", 32'h202, 3'b001, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    run_store("sb", 32'h001, 3'b000, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);

    // LHU with global stall during BUSY
    set_idle();
    mem_rd = 1'b1; reg_wr = 1'b1; reg_addr_rd = 5'd3; reg_data_rd = 32'h4;
    mem_size = 3'b101; dmem_rdata = 32'h0000_F00D;
    tick();
    stall = 1'b1; dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lhu_req_drop", dmem_req, 1'b0);
    tick();
    chk("lhu_held_wr", out_reg_wr, 1'b0);
    chk("lhu_held_req", dmem_req, 1'b0);
    chk("lhu_held_stallreq", stall_req, 1'b0);
    stall = 1'b0;
    tick();
    chk("lhu_wr", out_reg_wr, 1'b1);
    chk("lhu_data", out_reg_data_rd, 32'h0000_F00D);

    run_load("lh", 32'h6, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
    run_load("lbu", 32'h1, 3'b100, 32'h0000_9900, 32'h0000_0099);

    // flushed load is a bubble
    set_idle();
    flush = 1'b1; mem_rd = 1'b1; reg_wr = 1'b1; reg_data_rd = 32'h10; mem_size = 3'b010;
    #1;
    chk("fl_stallreq", stall_req, 1'b0);
    tick();
    chk("fl_req", dmem_req, 1'b0);
    chk("fl_flush", out_flush, 1'b1);
    chk("fl_wr", out_reg_wr, 1'b0);

    // reset while BUSY, then a clean load
    set_idle();
    mem_rd = 1'b1; reg_wr = 1'b1; reg_addr_rd = 5'd2; reg_data_rd = 32'h8; mem_size = 3'b010;
    tick();
    chk("rb_req", dmem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_req_async", dmem_req, 1'b0);
    chk("rb_flush", out_flush, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rb_req_again", dmem_req, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    tick();
    chk("rb_wr", out_reg_wr, 1'b1);
    chk("rb_data", out_reg_data_rd, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
